sample_pacer: RTL and testbench
===============================

# sample_pacer

Input-side pacing stage for the sequential FIR datapath. Accepts 16-bit samples in bursts from the ADC/stimulus side over a valid/ready handshake, buffers them in a small FIFO, and releases them to the filter as single-cycle `val_out` strobes no closer than `Period` cycles apart. This guarantees the time-multiplexed MAC gets its full coefficient sweep per sample. `dout`/`val_out` connect directly to the filter's `din`/`val_in`.

## Interface
- `Win`, 16, sample width in and out
- `Depth`, 8, FIFO entries; power of two, ≥2
- `Period`, 20, minimum cycles between `val_out` pulses; ≥1; set ≥ filter `Num_coef`+3

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `din`  in  `Win`  signed input sample
- `val_in`  in  1  input sample valid
- `rdy_out`  out  1  FIFO can accept; `!full`
- `dout`  out  `Win`  signed sample to filter, registered
- `val_out`  out  1  one-cycle strobe, `dout` valid
- `level`  out  `log2(Depth+1)`  current FIFO occupancy
- `ovf`  out  1  sticky: a sample was offered while full

## Operation
- Write accept: `val_in && rdy_out` at a rising edge. The sample is stored at `wr_ptr`, then `wr_ptr` increments modulo `Depth`.
- Write while full (`val_in && !rdy_out`): sample dropped, no pointer or level change, `ovf` ← 1. `ovf` clears only on reset.
- `rdy_out` is combinational from the registered `level`: `level != Depth`. A pop in the same cycle does not make room for a write in that cycle.
- Pacing counter `cnt`, width `log2(Period)` (min 1):
  - IDLE (`cnt==0`): if `level>0`, pop. `dout` ← mem[`rd_ptr`], `val_out` ← 1, `rd_ptr` increments modulo `Depth`, `cnt` ← `Period-1`, go to WAIT. Otherwise `val_out` ← 0.
  - WAIT (`cnt>0`): `cnt` decrements, `val_out` ← 0, no pop. Return to IDLE when `cnt` reaches 0.
- `Period==1`: `cnt` stays 0. The block pops every cycle while non-empty.
- `level` update per edge:
  - +1 on an accepted write only
  - −1 on a pop only
  - unchanged when both occur
- `dout` holds its last value between strobes. There is no width change and no arithmetic on data.
- Reset values:
  - `dout`=0, `val_out`=0, `ovf`=0, `level`=0
  - `rd_ptr`=`wr_ptr`=0, `cnt`=0 (IDLE)
  - `rdy_out`=1 while in reset
  - FIFO memory not reset
- Reset asserted mid-operation discards all buffered samples immediately. Any `val_out` in flight drops to 0 asynchronously.

## Timing
- Latency into an empty FIFO with IDLE: a sample accepted at edge t produces `val_out`=1 with that sample on `dout` after edge t+1.
- Sustained spacing with a non-empty FIFO: consecutive `val_out` rising edges are exactly `Period` cycles apart.
- A sample arriving during WAIT is emitted after the edge at which `cnt` has reached 0, with a pop at the next IDLE edge. Spacing is never less than `Period`.
- Full boundary: with `level`=`Depth`, a pop and an offered write in the same edge give `level`=`Depth-1` and the write is dropped with `ovf` set. `rdy_out` reasserts the following cycle.
- Empty boundary: a write and a pop decision in the same edge with `level`=0 does not pop. The pop happens at the next edge.
- Pointer wrap: indices go `Depth-1` → 0 with no gap. Data order is preserved across the wrap.

## Structure
- Shared package or include: `log2` ceiling function, identical to the one used by the filter stages. Also holds the reset-polarity constant.
- Sub-module `sync_fifo` (`Win`, `Depth`): memory, pointers, `level`, full/empty, `ovf`, with push/pop inputs.
- The top level holds the pacing counter and the IDLE/WAIT state, and registers `dout`/`val_out`.

## Test plan
- Reset: drive `rst`=0 mid-burst → all outputs at reset values, including `rdy_out`=1 and `level`=0. After release, the first sample 0x1234 appears on `dout` with `val_out` one edge after acceptance.
- Burst of 8 samples (1..8) on consecutive cycles, Depth 8, Period 20:
  - `val_out` pulses at cycles c, c+20, …, c+140
  - `dout` = 1..8 in order
  - `ovf` stays 0
- Burst of 10 samples, Depth 8, Period 20:
  - `rdy_out` drops when `level` = 8
  - samples 10 (and 9 if offered before room frees) are dropped
  - `ovf`=1 and stays 1
  - output is 1..8 (or 1..9), in order
- `Period`=1, stream of 20 alternating ±0x7FFF/−0x8000 samples → back-to-back `val_out` with exact values, and pointers wrap twice without corruption.
- Full-plus-pop: fill to 8, then offer a write on the pop edge → `level` goes 8→7 and the write is dropped. A write the next cycle is accepted and `level` returns to 8.
- Integration with the filter (`Num_coef`=17, Period 20) driven with an impulse 0x4000 then zeros → filter `val_out` count equals the input count, and the outputs reproduce the coefficients.

Source files
------------

// File: rtl/sample_pacer_pkg.sv
// Shared definitions for the sample pacer and the filter stages.
// Holds the ceiling-log2 helper used for all derived widths, the reset
// polarity constant and the pacing state encoding.
package sample_pacer_pkg;

    // Reset is asserted low.
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } pace_state_t;

    // Ceiling log2: smallest r with 2**r >= x (log2(1) == 0).
    function automatic int unsigned log2(input int unsigned x);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(x)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and sticky overflow flag.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, din      write request and data; dropped when full
//   pop            read request; ignored when empty
//   rd_data_c      head-of-queue data (combinational)
//   level          registered occupancy, 0..Depth
//   full_c/empty_c status derived from level
//   ovf            sticky: a push was offered while full
module sync_fifo
    import sample_pacer_pkg::*;
#(
    parameter int unsigned Win   = 16,
    parameter int unsigned Depth = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [Win-1:0]              din,
    output logic [Win-1:0]              rd_data_c,
    output logic [log2(Depth+1)-1:0]    level,
    output logic                        full_c,
    output logic                        empty_c,
    output logic                        ovf
);

    localparam int unsigned PW = log2(Depth);
    localparam int unsigned LW = log2(Depth + 1);

    logic [Win-1:0] mem [Depth];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           accept_c;
    logic           pop_ok_c;

    assign full_c    = (level == LW'(Depth));
    assign empty_c   = (level == '0);
    assign accept_c  = push && !full_c;
    assign pop_ok_c  = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept_c, pop_ok_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && full_c) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_pacer.sv
// Input pacing stage for the sequential FIR: buffers bursty samples and
// releases them as single-cycle strobes at least Period cycles apart.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   din       input sample, val_in marks it valid
//   rdy_out   FIFO can accept (not full), combinational from level
//   dout      registered sample to the filter, held between strobes
//   val_out   one-cycle strobe qualifying dout
//   level     FIFO occupancy
//   ovf       sticky overflow: a sample was offered while full
module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int unsigned Win    = 16,
    parameter int unsigned Depth  = 8,
    parameter int unsigned Period = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [Win-1:0]              din,
    input  logic                        val_in,
    output logic                        rdy_out,
    output logic [Win-1:0]              dout,
    output logic                        val_out,
    output logic [log2(Depth+1)-1:0]    level,
    output logic                        ovf
);

    localparam int unsigned CW = (log2(Period) > 0) ? log2(Period) : 1;

    pace_state_t    state_q;
    pace_state_t    state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [Win-1:0] dout_d;
    logic           val_out_d;
    logic           pop_c;
    logic [Win-1:0] rd_data_c;
    logic           full_c;
    logic           empty_c;

    sync_fifo #(
        .Win   (Win),
        .Depth (Depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (val_in),
        .pop       (pop_c),
        .din       (din),
        .rd_data_c (rd_data_c),
        .level     (level),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .ovf       (ovf)
    );

    // Based on the registered level, so a same-cycle pop never frees a slot.
    assign rdy_out = !full_c;

    // State, pacing counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout    <= '0;
            val_out <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout    <= dout_d;
            val_out <= val_out_d;
        end
    end

    // Pop when idle and non-empty, then hold off for Period-1 cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout;
        val_out_d = 1'b0;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    val_out_d = 1'b1;
                    dout_d    = rd_data_c;
                    // Period of 1 never leaves IDLE: back-to-back pops.
                    if (Period > 1) begin
                        cnt_d   = CW'(Period - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer: a Period=20 instance for burst, overflow,
// full-boundary and reset behaviour, and a Period=1 instance for streaming.
module tb_sample_pacer;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        val_in;
    logic        rdy_out;
    logic [15:0] dout;
    logic        val_out;
    logic [3:0]  level;
    logic        ovf;

    logic [15:0] p1_din;
    logic        p1_val_in;
    logic        p1_rdy_out;
    logic [15:0] p1_dout;
    logic        p1_val_out;
    logic [3:0]  p1_level;
    logic        p1_ovf;

    int total = 0;
    int bad   = 0;

    sample_pacer #(.Win(16), .Depth(8), .Period(20)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .val_in  (val_in),
        .rdy_out (rdy_out),
        .dout    (dout),
        .val_out (val_out),
        .level   (level),
        .ovf     (ovf)
    );

    sample_pacer #(.Win(16), .Depth(8), .Period(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .din     (p1_din),
        .val_in  (p1_val_in),
        .rdy_out (p1_rdy_out),
        .dout    (p1_dout),
        .val_out (p1_val_out),
        .level   (p1_level),
        .ovf     (p1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle drive schedule and optional checks for the Period=20 instance.
    logic        drv_val [256];
    logic [15:0] drv_dat [256];
    int          chk_lvl [256];
    int          chk_rdy [256];
    logic [15:0] exp_q [$];

    typedef struct {
        logic        val_in;
        logic [15:0] din;
        logic        exp_val;
        logic [15:0] exp_dout;
        logic [3:0]  exp_level;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) begin
            drv_val[i] = 1'b0;
            drv_dat[i] = 16'h0;
            chk_lvl[i] = -1;
            chk_rdy[i] = -1;
        end
        exp_q.delete();
    endtask

    // Applies the schedule; every strobe must land on cycle 1+20*p with the next expected sample.
    task automatic run_seq(input int n);
        int p;
        p = 0;
        for (int k = 0; k < n; k++) begin
            val_in = drv_val[k];
            din    = drv_dat[k];
            step();
            if (val_out) begin
                if (p < exp_q.size()) begin
                    check("pulse_cycle", k, 1 + 20 * p);
                    check("pulse_data", 32'(dout), 32'(exp_q[p]));
                end else begin
                    check("extra_pulse", p, exp_q.size());
                end
                p++;
            end
            if (chk_lvl[k] >= 0) check("level", 32'(level), chk_lvl[k]);
            if (chk_rdy[k] >= 0) check("rdy_out", 32'(rdy_out), chk_rdy[k]);
        end
        val_in = 1'b0;
        check("pulse_count", p, exp_q.size());
    endtask

    function automatic logic [15:0] pat(input int k);
        logic [15:0] v;
        case (k % 4)
            0:       v = 16'h7FFF;
            1:       v = 16'h8000;
            2:       v = 16'h8001;
            default: v = {8'(k), 8'(k + 16)};
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b0; din = 16'h0; val_in = 1'b0;
        p1_din = 16'h0; p1_val_in = 1'b0;

        // Period=1 stream table: sample k pops one edge after its write.
        for (int k = 0; k < 22; k++) begin
            tbl[k].val_in    = (k < 20);
            tbl[k].din       = (k < 20) ? pat(k) : 16'h0;
            tbl[k].exp_val   = (k >= 1 && k <= 20);
            tbl[k].exp_dout  = (k == 0) ? 16'h0 : pat((k <= 20) ? k - 1 : 19);
            tbl[k].exp_level = (k < 20) ? 4'd1 : 4'd0;
        end

        // Reset values
        #12;
        check("rst_dout", 32'(dout), 0);
        check("rst_val_out", 32'(val_out), 0);
        check("rst_level", 32'(level), 0);
        check("rst_rdy", 32'(rdy_out), 1);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_p1_rdy", 32'(p1_rdy_out), 1);
        rst = 1'b1;
        step();

        // Burst of 8 fits exactly, no overflow
        clear_sched();
        for (int k = 0; k < 8; k++) begin
            drv_val[k] = 1'b1;
            drv_dat[k] = 16'(k + 1);
            exp_q.push_back(16'(k + 1));
        end
        chk_lvl[7] = 7; chk_rdy[7] = 1;
        chk_lvl[169] = 0;
        run_seq(170);
        check("burst8_ovf", 32'(ovf), 0);

        // Burst of 10: sample 10 dropped, overflow sticks
        clear_sched();
        for (int k = 0; k < 10; k++) begin
            drv_val[k] = 1'b1;
            drv_dat[k] = 16'(k + 1);
            if (k < 9) exp_q.push_back(16'(k + 1));
        end
        chk_lvl[7] = 7;
        chk_lvl[8] = 8; chk_rdy[8] = 0;
        chk_lvl[9] = 8;
        chk_rdy[20] = 0;
        chk_lvl[21] = 7; chk_rdy[21] = 1;
        chk_lvl[199] = 0;
        run_seq(200);
        check("burst10_ovf", 32'(ovf), 1);

        // Full plus pop: write on the pop edge is dropped, next write lands
        clear_sched();
        for (int k = 0; k < 9; k++) begin
            drv_val[k] = 1'b1;
            drv_dat[k] = 16'h0100 + 16'(k);
            exp_q.push_back(16'h0100 + 16'(k));
        end
        drv_val[21] = 1'b1; drv_dat[21] = 16'hAAAA;
        drv_val[22] = 1'b1; drv_dat[22] = 16'hBBBB;
        exp_q.push_back(16'hBBBB);
        chk_lvl[8]  = 8;
        chk_lvl[20] = 8; chk_rdy[20] = 0;
        chk_lvl[21] = 7; chk_rdy[21] = 1;
        chk_lvl[22] = 8; chk_rdy[22] = 0;
        chk_lvl[209] = 0;
        run_seq(210);

        // Reset mid-burst clears everything, val_out drops asynchronously
        for (int k = 0; k < 4; k++) begin
            val_in = 1'b1;
            din    = 16'h0011 + 16'(k);
            step();
            if (k == 1) begin
                check("pre_rst_val", 32'(val_out), 1);
                check("pre_rst_dout", 32'(dout), 32'h11);
            end
        end
        check("pre_rst_level", 32'(level), 3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_val_out", 32'(val_out), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_rdy", 32'(rdy_out), 1);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_dout", 32'(dout), 0);
        val_in = 1'b0;
        step();
        step();
        #2 rst = 1'b1;

        // First sample after reset: one edge of latency
        #1;
        val_in = 1'b1; din = 16'h1234;
        step();
        check("lat_level", 32'(level), 1);
        check("lat_val0", 32'(val_out), 0);
        val_in = 1'b0;
        step();
        check("lat_val1", 32'(val_out), 1);
        check("lat_dout", 32'(dout), 32'h1234);
        check("lat_level_after", 32'(level), 0);
        step();
        check("lat_strobe_len", 32'(val_out), 0);
        check("lat_hold", 32'(dout), 32'h1234);

        // Period=1 streaming with two pointer wraps
        for (int k = 0; k < 22; k++) begin
            p1_val_in = tbl[k].val_in;
            p1_din    = tbl[k].din;
            step();
            check("p1_val_out", 32'(p1_val_out), 32'(tbl[k].exp_val));
            check("p1_dout", 32'(p1_dout), 32'(tbl[k].exp_dout));
            check("p1_level", 32'(p1_level), 32'(tbl[k].exp_level));
        end
        p1_val_in = 1'b0;
        check("p1_ovf", 32'(p1_ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
